// File: rtl/manchester_pkg.sv
// manchester_pkg: shared state encoding, bit-period helper and default delimiter for the Manchester receive path
package manchester_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HUNT,
      ST_LEN,
      ST_PAYLOAD,
      ST_DRAIN,
      ST_ERR,
      ST_REARM
   } state_t;
   localparam logic [7:0] SYNC_DEFAULT = 8'hD5;
   function automatic int bit_t(input int osc_fre, input int data_rate);
      return osc_fre / data_rate;
   endfunction
endpackage

// File: rtl/mdec_sync_edge.sv
// mdec_sync_edge: brings decoder data/clock into the osc domain and strobes each new bit
//   osc, rst_n         : system clock, async active-low reset
//   recovered_data     : decoder data (async)
//   balanced_clk       : decoder bit clock (async), rising edge marks a new bit
//   bit_stb, bit_val   : one-cycle strobe per bit and the bit value sampled with it
module mdec_sync_edge (
   input  logic osc,
   input  logic rst_n,
   input  logic recovered_data,
   input  logic balanced_clk,
   output logic bit_stb,
   output logic bit_val
);
   logic d1, d2, c1, c2, c3;
   always_ff @(posedge osc or negedge rst_n) begin
      if (!rst_n) begin
         {d1, d2} <= '0;
         {c1, c2, c3} <= '0;
      end else begin
         {d2, d1} <= {d1, recovered_data};
         {c3, c2, c1} <= {c2, c1, balanced_clk};
      end
   end
   // data and clock share the same synchronizer depth, so d2 pairs with the edge seen on c2
   assign bit_stb = c2 & ~c3;
   assign bit_val = d2;
endmodule

// File: rtl/manchester_rx_ctrl.sv
// manchester_rx_ctrl: hunts the sync word, reads a length byte and hands payload bytes to a valid/ready consumer
//   osc, rst_n                         : system clock, async active-low reset
//   rx_en                              : receive enable level
//   recovered_data, balanced_clk       : decoder outputs (async)
//   dec_rst_n                          : active-low decoder re-arm reset
//   byte_data, byte_valid, byte_ready  : payload handshake
//   frame_start, frame_end, frame_err  : one-cycle frame event pulses
//   busy                               : frame in progress
module manchester_rx_ctrl
   import manchester_pkg::*;
#(
   parameter int         OSC_FRE     = 32,
   parameter int         DATA_RATE   = 2,
   parameter logic [7:0] SYNC_WORD   = SYNC_DEFAULT,
   parameter int         MAX_LEN     = 16,
   parameter int         DEC_RST_CYC = 4
) (
   input  logic       osc,
   input  logic       rst_n,
   input  logic       rx_en,
   input  logic       recovered_data,
   input  logic       balanced_clk,
   output logic       dec_rst_n,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       frame_start,
   output logic       frame_end,
   output logic       frame_err,
   output logic       busy
);
   localparam int BIT_T  = bit_t(OSC_FRE, DATA_RATE);
   localparam int TO_MAX = 2 * BIT_T;
   localparam int TW     = $clog2(TO_MAX + 1);
   localparam int RW     = $clog2(DEC_RST_CYC + 1);
   logic          bit_stb, bit_val;
   state_t        state;
   logic [7:0]    win, shreg, len, byte_cnt;
   logic [2:0]    bit_cnt;
   logic [TW-1:0] to_cnt;
   logic [RW-1:0] rst_cnt;
   logic [7:0]    new_win, new_byte;
   logic          accept, timeout;
   mdec_sync_edge u_sync (
      .osc            (osc),
      .rst_n          (rst_n),
      .recovered_data (recovered_data),
      .balanced_clk   (balanced_clk),
      .bit_stb        (bit_stb),
      .bit_val        (bit_val)
   );
   assign new_win   = {win[6:0], bit_val};
   assign new_byte  = {shreg[6:0], bit_val};
   assign accept    = byte_valid & byte_ready;
   assign timeout   = !bit_stb && to_cnt == TW'(TO_MAX - 1);
   // combinational so the pulse coincides with the consumer taking the last byte
   assign frame_end = state == ST_DRAIN && accept;
   always_ff @(posedge osc or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         win         <= '0;
         shreg       <= '0;
         len         <= '0;
         byte_cnt    <= '0;
         bit_cnt     <= '0;
         to_cnt      <= '0;
         rst_cnt     <= '0;
         dec_rst_n   <= 1'b1;
         byte_data   <= '0;
         byte_valid  <= 1'b0;
         frame_start <= 1'b0;
         frame_err   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         frame_err   <= 1'b0;
         busy        <= state inside {ST_LEN, ST_PAYLOAD, ST_DRAIN};
         if (accept) byte_valid <= 1'b0;
         to_cnt <= bit_stb ? '0 : to_cnt == TW'(TO_MAX) ? to_cnt : to_cnt + TW'(1);
         if (!rx_en && state != ST_REARM) begin
            state      <= ST_IDLE;
            byte_valid <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state <= ST_HUNT;
                  win   <= '0;
               end
               ST_HUNT: if (bit_stb) begin
                  win <= new_win;
                  if (new_win == SYNC_WORD) begin
                     state       <= ST_LEN;
                     frame_start <= 1'b1;
                     bit_cnt     <= '0;
                     to_cnt      <= '0;
                  end
               end
               ST_LEN: begin
                  if (timeout) begin
                     state     <= ST_ERR;
                     frame_err <= 1'b1;
                  end else if (bit_stb) begin
                     shreg   <= new_byte;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (new_byte == 8'd0 || new_byte > 8'(MAX_LEN)) begin
                           state     <= ST_ERR;
                           frame_err <= 1'b1;
                        end else begin
                           len      <= new_byte;
                           byte_cnt <= '0;
                           state    <= ST_PAYLOAD;
                        end
                     end
                  end
               end
               ST_PAYLOAD: begin
                  if (timeout) begin
                     state      <= ST_ERR;
                     frame_err  <= 1'b1;
                     byte_valid <= 1'b0;
                  end else if (bit_stb) begin
                     shreg   <= new_byte;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        // an unaccepted byte would be overwritten: abort instead
                        if (byte_valid && !byte_ready) begin
                           state      <= ST_ERR;
                           frame_err  <= 1'b1;
                           byte_valid <= 1'b0;
                        end else begin
                           byte_data  <= new_byte;
                           byte_valid <= 1'b1;
                           byte_cnt   <= byte_cnt + 8'd1;
                           if (byte_cnt + 8'd1 == len) state <= ST_DRAIN;
                        end
                     end
                  end
               end
               ST_DRAIN: if (accept) begin
                  state     <= ST_REARM;
                  dec_rst_n <= 1'b0;
                  rst_cnt   <= '0;
               end
               ST_ERR: begin
                  state     <= ST_REARM;
                  dec_rst_n <= 1'b0;
                  rst_cnt   <= '0;
               end
               ST_REARM: begin
                  rst_cnt <= rst_cnt + RW'(1);
                  if (rst_cnt == RW'(DEC_RST_CYC - 1)) begin
                     dec_rst_n <= 1'b1;
                     win       <= '0;
                     state     <= rx_en ? ST_HUNT : ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_manchester_rx_ctrl.sv
// tb_manchester_rx_ctrl: scoreboard bench driving a decoder-output model into manchester_rx_ctrl
module tb_manchester_rx_ctrl;
   localparam int BIT_T       = 16;
   localparam int MAX_LEN     = 16;
   localparam int DEC_RST_CYC = 4;
   localparam logic [7:0] SYNC = 8'hD5;
   localparam int EV_START = 0, EV_BYTE = 1, EV_END = 2, EV_ERR = 3;
   logic       osc = 1'b0, rst_n = 1'b0, rx_en = 1'b0;
   logic       recovered_data = 1'b0, balanced_clk = 1'b0, byte_ready = 1'b1;
   logic       dec_rst_n, byte_valid, frame_start, frame_end, frame_err, busy;
   logic [7:0] byte_data;
   int         tests = 0, fails = 0;
   int         cyc = 0, rise_cyc = 0, err_cyc = 0, low_cnt = 0;
   bit         busy_seen = 1'b0;
   logic [9:0] exp_q[$];
   bit         stream[$];
   always #5 osc = ~osc;
   always @(posedge osc) cyc <= cyc + 1;
   manchester_rx_ctrl #(
      .OSC_FRE(32), .DATA_RATE(2), .SYNC_WORD(SYNC), .MAX_LEN(MAX_LEN), .DEC_RST_CYC(DEC_RST_CYC)
   ) dut (
      .osc            (osc),
      .rst_n          (rst_n),
      .rx_en          (rx_en),
      .recovered_data (recovered_data),
      .balanced_clk   (balanced_clk),
      .dec_rst_n      (dec_rst_n),
      .byte_data      (byte_data),
      .byte_valid     (byte_valid),
      .byte_ready     (byte_ready),
      .frame_start    (frame_start),
      .frame_end      (frame_end),
      .frame_err      (frame_err),
      .busy           (busy)
   );
   function automatic void chk(input string name, input int act, input int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endfunction
   function automatic void expect_ev(input int kind, input logic [7:0] d);
      exp_q.push_back({kind[1:0], d});
   endfunction
   function automatic void observe(input string name, input logic [9:0] got);
      logic [9:0] e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL %s: unexpected event %0h, nothing expected", name, got);
      end else begin
         e = exp_q.pop_front();
         if (e != got) begin
            fails++;
            $display("FAIL %s: got event %0h, expected %0h", name, got, e);
         end
      end
   endfunction
   always @(negedge osc) if (rst_n) begin
      if (frame_start) observe("frame_start", {2'(EV_START), 8'h00});
      if (byte_valid && byte_ready) observe("byte", {2'(EV_BYTE), byte_data});
      if (frame_end) observe("frame_end", {2'(EV_END), 8'h00});
      if (frame_err) begin
         err_cyc = cyc;
         observe("frame_err", {2'(EV_ERR), 8'h00});
      end
      if (frame_start || frame_end || frame_err)
         chk("pulse_excl", int'(frame_start) + int'(frame_end) + int'(frame_err), 1);
      if (busy) busy_seen = 1'b1;
      if (!dec_rst_n) low_cnt++;
      else if (low_cnt != 0) begin
         chk("dec_rst_low_cycles", low_cnt, DEC_RST_CYC);
         low_cnt = 0;
      end
   end
   function automatic void push_byte(input logic [7:0] v);
      for (int j = 7; j >= 0; j--) stream.push_back(v[j]);
   endfunction
   function automatic int find_sync();
      logic [7:0] w = '0;
      for (int i = 0; i < stream.size(); i++) begin
         w = {w[6:0], stream[i]};
         if (w == SYNC) return i;
      end
      return -1;
   endfunction
   function automatic logic [7:0] get_byte(input int idx);
      logic [7:0] v = '0;
      for (int j = 0; j < 8; j++) v = {v[6:0], stream[idx + j]};
      return v;
   endfunction
   // frame rules applied to the whole bit stream: stall = number of bytes accepted before the consumer stops
   function automatic void model(input int stall);
      int pos, idx, ln;
      logic [7:0] v;
      pos = find_sync();
      if (pos < 0) return;
      expect_ev(EV_START, 8'h00);
      idx = pos + 1;
      if (stream.size() - idx < 8) begin expect_ev(EV_ERR, 8'h00); return; end
      ln = int'(get_byte(idx));
      idx += 8;
      if (ln == 0 || ln > MAX_LEN) begin expect_ev(EV_ERR, 8'h00); return; end
      for (int k = 0; k < ln; k++) begin
         if (stream.size() - idx < 8) begin expect_ev(EV_ERR, 8'h00); return; end
         v = get_byte(idx);
         idx += 8;
         if (k == stall + 1) begin expect_ev(EV_ERR, 8'h00); return; end
         if (!(k == stall && k != ln - 1)) expect_ev(EV_BYTE, v);
      end
      expect_ev(EV_END, 8'h00);
   endfunction
   task automatic send_bits(input int n);
      @(negedge osc);
      for (int i = 0; i < n; i++) begin
         recovered_data = stream[i];
         repeat (BIT_T / 2) @(negedge osc);
         balanced_clk = 1'b1;
         rise_cyc = cyc;
         repeat (BIT_T / 2) @(negedge osc);
         balanced_clk = 1'b0;
      end
   endtask
   task automatic wait_empty(input string name, input int idle);
      int k = 0;
      while (exp_q.size() != 0 && k < 400) begin
         @(negedge osc);
         k++;
      end
      chk(name, exp_q.size(), 0);
      exp_q.delete();
      repeat (idle) @(negedge osc);
   endtask
   task automatic run_frame(input string name);
      model(1000);
      send_bits(stream.size());
      wait_empty(name, 40);
   endtask
   task automatic std_frame();
      stream.delete();
      push_byte(SYNC); push_byte(8'h03); push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
   endtask
   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_dec_rst_n"}, dec_rst_n, 1);
      chk({tag, "_byte_valid"}, byte_valid, 0);
      chk({tag, "_byte_data"}, byte_data, 0);
      chk({tag, "_frame_start"}, frame_start, 0);
      chk({tag, "_frame_end"}, frame_end, 0);
      chk({tag, "_frame_err"}, frame_err, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      int nn, ln;
      repeat (3) @(negedge osc);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge osc);
      rx_en = 1'b1;
      repeat (4) @(negedge osc);
      std_frame();
      busy_seen = 1'b0;
      run_frame("t1_frame");
      chk("t1_busy_seen", busy_seen, 1);
      chk("t1_valid_after", byte_valid, 0);
      std_frame();
      model(1);
      fork
         send_bits(stream.size());
         begin
            int k = 0;
            do begin @(negedge osc); k++; end while (!(byte_valid && byte_ready) && k < 5000);
            @(posedge osc);
            #1 byte_ready = 1'b0;
         end
      join
      wait_empty("t2_overflow", 10);
      chk("t2_valid_dropped", byte_valid, 0);
      byte_ready = 1'b1;
      repeat (30) @(negedge osc);
      stream.delete(); push_byte(SYNC); push_byte(8'h00);
      run_frame("t3_len0");
      stream.delete(); push_byte(SYNC); push_byte(8'h11);
      run_frame("t3_len17");
      chk("t3_no_valid", byte_valid, 0);
      stream.delete(); push_byte(SYNC); push_byte(8'h02); push_byte(8'hA1);
      run_frame("t4_timeout");
      chk("t4_timeout_cycles", err_cyc - rise_cyc, 2 * BIT_T + 3);
      stream.delete();
      push_byte(8'h55); push_byte(8'h6B); push_byte(SYNC);
      push_byte(8'h03); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
      run_frame("t5_noise");
      for (int r = 0; r < 5; r++) begin
         do begin
            stream.delete();
            nn = $urandom_range(0, 3);
            for (int i = 0; i < nn; i++) push_byte(8'($urandom));
            push_byte(SYNC);
         end while (find_sync() != stream.size() - 1);
         ln = $urandom_range(1, 8);
         push_byte(8'(ln));
         for (int i = 0; i < ln; i++) push_byte(8'($urandom));
         run_frame("rand_frame");
      end
      std_frame();
      expect_ev(EV_START, 8'h00);
      expect_ev(EV_BYTE, 8'hA1);
      send_bits(28);
      rx_en = 1'b0;
      repeat (3) @(negedge osc);
      chk("t6_valid_cleared", byte_valid, 0);
      chk("t6_busy_idle", busy, 0);
      repeat (60) @(negedge osc);
      wait_empty("t6_rx_en_drop", 0);
      rx_en = 1'b1;
      repeat (4) @(negedge osc);
      expect_ev(EV_START, 8'h00);
      expect_ev(EV_BYTE, 8'hA1);
      send_bits(28);
      wait_empty("t6_before_reset", 0);
      rst_n = 1'b0;
      repeat (2) @(negedge osc);
      chk_reset_outputs("t6_in_reset");
      rst_n = 1'b1;
      @(negedge osc);
      chk_reset_outputs("t6_after_reset");
      repeat (60) @(negedge osc);
      stream.delete(); push_byte(SYNC); push_byte(8'h02); push_byte(8'h5A); push_byte(8'hC3);
      run_frame("t6_recover");
      chk("final_queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
